// File: rtl/ray_scanner.sv
// ----------------------------------------------------------------------------
// ray_scanner
// Walks one ray of the board, starting from an origin square and moving in one
// of eight directions. Squares are read one at a time through the board-state
// memory read port. The scan stops at the first occupied square, at the board
// edge, or at the step limit, whichever comes first. It reports the hit square,
// the piece on it, and how many empty squares were crossed on the way.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           scan request, only looked at while idle
//   origin          start square, row*BOARD_DIM+col (row 0 is the top row)
//   direction       000 UP, 001 LEFT, 010 RIGHT, 011 DOWN,
//                   100 UP_LEFT, 101 UP_RIGHT, 110 DOWN_LEFT, 111 DOWN_RIGHT
//   max_steps       ray length limit, 0 = unlimited
//   rd_en, rd_addr  board memory read request
//   rd_data         piece code, valid the cycle after rd_en
//   busy            scan in progress (ISSUE/WAIT/DONE)
//   done            one-cycle end-of-scan pulse
//   found, nearest_pos, nearest_piece, empty_count   scan result, held until
//                   the next accepted start
// ----------------------------------------------------------------------------
module ray_scanner #(
    parameter int BOARD_DIM  = 8,
    parameter int POS_W      = 6,
    parameter int CNT_W      = 3,
    parameter int PIECE_W    = 3,
    parameter int EMPTY_CODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [POS_W-1:0]   origin,
    input  logic [2:0]         direction,
    input  logic [CNT_W-1:0]   max_steps,
    output logic               rd_en,
    output logic [POS_W-1:0]   rd_addr,
    input  logic [PIECE_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [POS_W-1:0]   nearest_pos,
    output logic [PIECE_W-1:0] nearest_piece,
    output logic [CNT_W-1:0]   empty_count
);

    localparam int                 NUM_SQ    = BOARD_DIM * BOARD_DIM;
    localparam logic [POS_W-1:0]   DIM_P     = POS_W'(BOARD_DIM);
    localparam logic [POS_W:0]     NUM_SQ_X  = (POS_W+1)'(NUM_SQ);
    localparam logic [CNT_W-1:0]   LAST_RC   = CNT_W'(BOARD_DIM - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [POS_W-1:0]   POS_ZERO  = {POS_W{1'b0}};
    localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
    localparam logic [PIECE_W-1:0] EMPTY_P   = PIECE_W'(EMPTY_CODE);

    localparam logic [2:0] DIR_UP         = 3'b000;
    localparam logic [2:0] DIR_LEFT       = 3'b001;
    localparam logic [2:0] DIR_RIGHT      = 3'b010;
    localparam logic [2:0] DIR_DOWN       = 3'b011;
    localparam logic [2:0] DIR_UP_LEFT    = 3'b100;
    localparam logic [2:0] DIR_UP_RIGHT   = 3'b101;
    localparam logic [2:0] DIR_DOWN_LEFT  = 3'b110;
    localparam logic [2:0] DIR_DOWN_RIGHT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;

    // Scan context captured at start; pos_r/row_r/col_r track the last square
    // visited (the origin before the first step).
    logic [POS_W-1:0] pos_r;
    logic [CNT_W-1:0] row_r;
    logic [CNT_W-1:0] col_r;
    logic [2:0]       dir_r;
    logic [CNT_W-1:0] max_r;
    logic [CNT_W-1:0] step_r;
    logic             origin_bad_r;

    logic             up_s;
    logic             down_s;
    logic             left_s;
    logic             right_s;
    logic             off_board_s;
    logic             limit_s;
    logic [POS_W-1:0] next_pos_s;
    logic [CNT_W-1:0] next_row_s;
    logic [CNT_W-1:0] next_col_s;
    logic             accept_s;
    logic             issue_s;
    logic             hit_s;
    logic             miss_s;

    // Split the latched direction into its vertical and horizontal components.
    always_comb begin
        up_s    = 1'b0;
        down_s  = 1'b0;
        left_s  = 1'b0;
        right_s = 1'b0;
        case (dir_r)
            DIR_UP:         up_s = 1'b1;
            DIR_LEFT:       left_s = 1'b1;
            DIR_RIGHT:      right_s = 1'b1;
            DIR_DOWN:       down_s = 1'b1;
            DIR_UP_LEFT:    begin up_s = 1'b1;   left_s = 1'b1;  end
            DIR_UP_RIGHT:   begin up_s = 1'b1;   right_s = 1'b1; end
            DIR_DOWN_LEFT:  begin down_s = 1'b1; left_s = 1'b1;  end
            DIR_DOWN_RIGHT: begin down_s = 1'b1; right_s = 1'b1; end
            default:        up_s = 1'b0;
        endcase
    end

    // Next square on the ray, plus the edge and step-limit stop conditions.
    // The linear address is stepped by +-BOARD_DIM / +-1 so no multiplier is
    // needed; the edge test on row/col prevents any wrap between rows.
    always_comb begin
        next_row_s = row_r;
        next_col_s = col_r;
        next_pos_s = pos_r;
        if (up_s) begin
            next_row_s = row_r - CNT_ONE;
            next_pos_s = pos_r - DIM_P;
        end else if (down_s) begin
            next_row_s = row_r + CNT_ONE;
            next_pos_s = pos_r + DIM_P;
        end else begin
            next_row_s = row_r;
        end
        if (left_s) begin
            next_col_s = col_r - CNT_ONE;
            next_pos_s = next_pos_s - POS_ONE;
        end else if (right_s) begin
            next_col_s = col_r + CNT_ONE;
            next_pos_s = next_pos_s + POS_ONE;
        end else begin
            next_col_s = col_r;
        end
        off_board_s = (up_s    && (row_r == CNT_ZERO)) ||
                      (down_s  && (row_r == LAST_RC))  ||
                      (left_s  && (col_r == CNT_ZERO)) ||
                      (right_s && (col_r == LAST_RC));
        limit_s     = (max_r != CNT_ZERO) && (step_r == max_r);
    end

    // Next-state logic and the control/handshake outputs.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        issue_s  = 1'b0;
        hit_s    = 1'b0;
        miss_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = S_ISSUE;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (origin_bad_r || off_board_s || limit_s) begin
                    state_s = S_DONE;
                end else begin
                    issue_s = 1'b1;
                    state_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rd_data != EMPTY_P) begin
                    hit_s   = 1'b1;
                    state_s = S_DONE;
                end else begin
                    miss_s  = 1'b1;
                    state_s = S_ISSUE;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
        rd_en   = issue_s;
        rd_addr = issue_s ? next_pos_s : POS_ZERO;
        busy    = (state_r != S_IDLE);
        done    = (state_r == S_DONE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Scan context and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_r         <= POS_ZERO;
            row_r         <= CNT_ZERO;
            col_r         <= CNT_ZERO;
            dir_r         <= 3'b000;
            max_r         <= CNT_ZERO;
            step_r        <= CNT_ZERO;
            origin_bad_r  <= 1'b0;
            found         <= 1'b0;
            nearest_pos   <= POS_ZERO;
            nearest_piece <= EMPTY_P;
            empty_count   <= CNT_ZERO;
        end else if (accept_s) begin
            pos_r         <= origin;
            row_r         <= CNT_W'(origin / DIM_P);
            col_r         <= CNT_W'(origin % DIM_P);
            dir_r         <= direction;
            max_r         <= max_steps;
            step_r        <= CNT_ZERO;
            origin_bad_r  <= ({1'b0, origin} >= NUM_SQ_X);
            found         <= 1'b0;
            nearest_pos   <= POS_ZERO;
            nearest_piece <= EMPTY_P;
            empty_count   <= CNT_ZERO;
        end else if (issue_s) begin
            pos_r         <= next_pos_s;
            row_r         <= next_row_s;
            col_r         <= next_col_s;
            step_r        <= step_r + CNT_ONE;
        end else if (hit_s) begin
            // pos_r already holds the square whose data is arriving now.
            found         <= 1'b1;
            nearest_pos   <= pos_r;
            nearest_piece <= rd_data;
        end else if (miss_s) begin
            empty_count   <= empty_count + CNT_ONE;
        end else begin
            pos_r         <= pos_r;
        end
    end

endmodule

// File: tb/tb_ray_scanner.sv
// ----------------------------------------------------------------------------
// tb_ray_scanner
// Two scanner instances (8x8 and 10x10 boards) share one board memory model.
// A behavioural ray walker predicts the reads, the result and the done
// latency of each scan; directed cases come first, then random boards/rays.
// ----------------------------------------------------------------------------
module tb_ray_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, start10;
    logic [5:0] origin8;
    logic [6:0] origin10;
    logic [2:0] dir_in;
    logic [2:0] max8;
    logic [3:0] max10;

    logic       rd_en8, busy8, done8, found8;
    logic [5:0] rd_addr8, npos8;
    logic [2:0] rd_data8, npiece8, ecnt8;
    logic       rd_en10, busy10, done10, found10;
    logic [6:0] rd_addr10, npos10;
    logic [2:0] rd_data10, npiece10;
    logic [3:0] ecnt10;

    logic [2:0] board [0:127];

    int total = 0;
    int bad   = 0;
    int bd    = 8;

    int o_en, o_addr, o_busy, o_done, o_found, o_pos, o_piece, o_ecnt;
    int exp_found, exp_pos, exp_piece, exp_empty, exp_lat;
    int exp_reads[$];
    int got_reads[$];

    always #5 clk = ~clk;

    ray_scanner #(.BOARD_DIM(8), .POS_W(6), .CNT_W(3), .PIECE_W(3), .EMPTY_CODE(0)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .origin(origin8),
        .direction(dir_in), .max_steps(max8), .rd_en(rd_en8), .rd_addr(rd_addr8),
        .rd_data(rd_data8), .busy(busy8), .done(done8), .found(found8),
        .nearest_pos(npos8), .nearest_piece(npiece8), .empty_count(ecnt8)
    );

    ray_scanner #(.BOARD_DIM(10), .POS_W(7), .CNT_W(4), .PIECE_W(3), .EMPTY_CODE(0)) dut10 (
        .clk(clk), .reset(reset), .start(start10), .origin(origin10),
        .direction(dir_in), .max_steps(max10), .rd_en(rd_en10), .rd_addr(rd_addr10),
        .rd_data(rd_data10), .busy(busy10), .done(done10), .found(found10),
        .nearest_pos(npos10), .nearest_piece(npiece10), .empty_count(ecnt10)
    );

    // Board memory: one-cycle read latency; junk (nonzero) when not read.
    always @(posedge clk) begin
        rd_data8  <= rd_en8  ? board[rd_addr8]  : 3'd7;
        rd_data10 <= rd_en10 ? board[rd_addr10] : 3'd7;
    end

    task automatic check_val(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (bd=%0d t=%0t)", tag, act, exp, bd, $time);
        end
    endtask

    task automatic sample_outs();
        if (bd == 8) begin
            o_en = int'(rd_en8);  o_addr = int'(rd_addr8); o_busy = int'(busy8);
            o_done = int'(done8); o_found = int'(found8);  o_pos = int'(npos8);
            o_piece = int'(npiece8); o_ecnt = int'(ecnt8);
        end else begin
            o_en = int'(rd_en10);  o_addr = int'(rd_addr10); o_busy = int'(busy10);
            o_done = int'(done10); o_found = int'(found10);  o_pos = int'(npos10);
            o_piece = int'(npiece10); o_ecnt = int'(ecnt10);
        end
    endtask

    task automatic drive_in(input bit s, input int org, input int dr, input int mx);
        start8   = s && (bd == 8);
        start10  = s && (bd == 10);
        origin8  = 6'(org);
        origin10 = 7'(org);
        dir_in   = 3'(dr);
        max8     = 3'(mx);
        max10    = 4'(mx);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 128; i++) board[i] = 3'd0;
    endtask

    task automatic fill_board(input int b);
        clear_board();
        for (int i = 0; i < b * b; i++)
            if ($urandom_range(0, 3) == 0) board[i] = 3'($urandom_range(1, 7));
    endtask

    // Reference: walk the ray on a (row, col) grid with a per-direction step.
    task automatic model_scan(input int b, input int org, input int dr, input int mx);
        int r, c, rs, cs, steps, addr;
        int drow[8] = '{-1, 0, 0, 1, -1, -1, 1, 1};
        int dcol[8] = '{0, -1, 1, 0, -1, 1, -1, 1};
        exp_reads.delete();
        exp_found = 0; exp_pos = 0; exp_piece = 0; exp_empty = 0; steps = 0;
        rs = drow[dr]; cs = dcol[dr];
        if (org < b * b) begin
            r = org / b;
            c = org % b;
            while (1) begin
                if (mx != 0 && steps == mx) break;
                r += rs; c += cs;
                if (r < 0 || r >= b || c < 0 || c >= b) break;
                addr = r * b + c;
                exp_reads.push_back(addr);
                steps++;
                if (board[addr] != 3'd0) begin
                    exp_found = 1; exp_pos = addr; exp_piece = int'(board[addr]);
                    break;
                end
                exp_empty++;
            end
        end
        exp_lat = exp_found ? 2 * exp_reads.size() + 1 : 2 * exp_empty + 2;
    endtask

    // Called just after a clock edge; returns just after a clock edge with
    // the scanner back in IDLE.
    task automatic run_scan(input int b, input int org, input int dr, input int mx, input bit poke);
        int lat, busy_bad, n;
        bd = b;
        model_scan(b, org, dr, mx);
        drive_in(1'b1, org, dr, mx);
        @(posedge clk); #1;
        got_reads.delete();
        lat = 0; busy_bad = 0;
        for (int k = 1; k <= 60; k++) begin
            sample_outs();
            if (o_en != 0) got_reads.push_back(o_addr);
            if (o_busy != 1) busy_bad++;
            if (o_done != 0) begin
                lat = k;
                break;
            end
            if (poke)
                drive_in(1'($urandom_range(0, 1)), $urandom_range(0, 127),
                         $urandom_range(0, 7), $urandom_range(0, 15));
            else
                drive_in(1'b0, org, dr, mx);
            @(posedge clk); #1;
        end
        check_val("latency", lat, exp_lat);
        check_val("busy_during", busy_bad, 0);
        check_val("found", o_found, exp_found);
        check_val("nearest_pos", o_pos, exp_pos);
        check_val("nearest_piece", o_piece, exp_piece);
        check_val("empty_count", o_ecnt, exp_empty);
        check_val("num_reads", got_reads.size(), exp_reads.size());
        n = (got_reads.size() < exp_reads.size()) ? got_reads.size() : exp_reads.size();
        for (int i = 0; i < n; i++) check_val("read_addr", got_reads[i], exp_reads[i]);
        // start asserted in the DONE cycle must be ignored
        drive_in(1'b1, $urandom_range(0, 63), $urandom_range(0, 7), 0);
        @(posedge clk); #1;
        drive_in(1'b0, 0, 0, 0);
        sample_outs();
        check_val("busy_after", o_busy, 0);
        check_val("done_single", o_done, 0);
        check_val("rd_en_idle", o_en, 0);
        check_val("hold_found", o_found, exp_found);
        check_val("hold_pos", o_pos, exp_pos);
        check_val("hold_empty", o_ecnt, exp_empty);
        @(posedge clk); #1;
    endtask

    initial begin
        int done_seen;
        int b, org, dr, mx;
        reset = 1'b1;
        clear_board();
        drive_in(1'b0, 0, 0, 0);
        start10 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            bd = (i == 0) ? 8 : 10;
            sample_outs();
            check_val("rst_busy", o_busy, 0);
            check_val("rst_done", o_done, 0);
            check_val("rst_found", o_found, 0);
            check_val("rst_pos", o_pos, 0);
            check_val("rst_piece", o_piece, 0);
            check_val("rst_ecnt", o_ecnt, 0);
            check_val("rst_rd_en", o_en, 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        clear_board();
        board[11] = 3'd5;
        run_scan(8, 27, 0, 0, 1'b0);   // UP: 19 empty, 11 hit
        run_scan(8, 7, 2, 0, 1'b0);    // RIGHT from right edge: no read, no wrap
        clear_board();
        run_scan(8, 0, 7, 0, 1'b0);    // DOWN_RIGHT across empty board
        run_scan(8, 36, 4, 1, 1'b0);   // UP_LEFT limited to one step

        // Reset while waiting for read data
        bd = 8;
        drive_in(1'b1, 0, 7, 0);
        @(posedge clk); #1;            // ISSUE
        drive_in(1'b0, 0, 7, 0);
        @(posedge clk); #1;            // WAIT
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sample_outs();
        check_val("mid_rst_busy", o_busy, 0);
        check_val("mid_rst_done", o_done, 0);
        check_val("mid_rst_found", o_found, 0);
        check_val("mid_rst_ecnt", o_ecnt, 0);
        check_val("mid_rst_rd_en", o_en, 0);
        done_seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            sample_outs();
            done_seen += o_done + o_busy;
        end
        check_val("mid_rst_quiet", done_seen, 0);
        run_scan(8, 0, 7, 0, 1'b0);

        // 10x10 board
        clear_board();
        board[90] = 3'd2;
        run_scan(10, 95, 1, 0, 1'b0);  // LEFT: 94..91 empty, 90 hit
        run_scan(10, 120, 0, 0, 1'b0); // origin off the board

        // Random boards and rays
        for (int t = 0; t < 80; t++) begin
            b = ($urandom_range(0, 1) == 0) ? 8 : 10;
            fill_board(b);
            org = (b == 8) ? $urandom_range(0, 63) : $urandom_range(0, 127);
            dr  = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 0) mx = 0;
            else mx = (b == 8) ? $urandom_range(1, 7) : $urandom_range(1, 15);
            run_scan(b, org, dr, mx, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
